wf_mem_loader: RTL

//  Owns the single-port waveform RAM and shares it between two users: the FX2 host

---
 rtl/wf_mem_loader_if.sv | 25 ++
 rtl/wf_mem_loader.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/wf_mem_loader_if.sv
// Waveform RAM port bundle. The loader drives address/data/enable; the RAM side
// returns read data and may stall the loader.
interface wf_mem_loader_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
);
    // Handshake: ram_we/ram_addr/ram_wdata are registered by the master and each
    // cycle with ram_we=1 is exactly one write. ram_stall=1 asks the master not to
    // issue a new write in the coming cycle; ram_rdata is valid one cycle after ram_addr.
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;
    logic              ram_stall;

    modport master (
        output ram_addr, ram_wdata, ram_we,
        input  ram_rdata, ram_stall
    );

    modport slave (
        input  ram_addr, ram_wdata, ram_we,
        output ram_rdata, ram_stall
    );
endinterface

// File: rtl/wf_mem_loader.sv
// Shares the single-port waveform RAM between the FX2 host loader (synchronised
// strobe + small FIFO) and the playback reader.
module wf_mem_loader #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wf_mem_clk,
    input  logic [DATA_W-1:0] wf_mem_data,
    input  logic              load_en,
    input  logic              play_en,
    input  logic [ADDR_W-1:0] play_addr,
    output logic [DATA_W-1:0] play_rdata,
    output logic              play_valid,
    output logic              busy,
    output logic              overflow,
    output logic [ADDR_W:0]   word_count,
    output logic [1:0]        dbg_state_o,
    wf_mem_loader_if.master   ram
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        sync_q;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W:0]   word_count_q, word_count_d;
    logic              overflow_q, overflow_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              ram_we_q, ram_we_d;
    logic              busy_q;
    logic [1:0]        play_pipe_q;

    logic rise, push, pop, accept, drop, flush, fifo_full, fifo_empty;

    // Two sync flops then an edge-detect flop on the asynchronous host strobe.
    assign rise       = sync_q[1] & ~sync_q[2];
    assign fifo_full  = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (cnt_q == '0);
    assign push       = rise && (state_q == S_LOAD);
    assign pop        = (state_q != S_IDLE) && !fifo_empty && !ram.ram_stall;
    assign accept     = push && (!fifo_full || pop);
    assign drop       = push && fifo_full && !pop;

    always_comb begin
        state_d      = state_q;
        wr_addr_d    = wr_addr_q;
        word_count_d = word_count_q;
        overflow_d   = overflow_q | drop;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        ram_we_d     = 1'b0;
        flush        = 1'b0;
        cnt_d        = cnt_q + CNT_W'(accept) - CNT_W'(pop);
        case (state_q)
            S_IDLE: begin
                if (play_en) ram_addr_d = play_addr;
                if (load_en) begin
                    state_d      = S_LOAD;
                    wr_addr_d    = '0;
                    word_count_d = '0;
                    overflow_d   = 1'b0;
                    flush        = 1'b1;
                end
            end
            S_LOAD, S_DRAIN: begin
                if (pop) begin
                    ram_we_d    = 1'b1;
                    ram_addr_d  = wr_addr_q;
                    ram_wdata_d = fifo_mem[rd_ptr_q];
                    wr_addr_d   = wr_addr_q + 1'b1;
                    if (word_count_q != CNT_MAX) word_count_d = word_count_q + 1'b1;
                end
                // Exit decisions look at the occupancy after this cycle's push/pop,
                // so a word arriving as load_en drops is still drained.
                if (state_q == S_LOAD) begin
                    if (!load_en) state_d = (cnt_d == '0) ? S_IDLE : S_DRAIN;
                end else if (cnt_d == '0) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            sync_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            wr_addr_q    <= '0;
            word_count_q <= '0;
            overflow_q   <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            ram_we_q     <= 1'b0;
            busy_q       <= 1'b0;
            play_pipe_q  <= '0;
        end else begin
            state_q      <= state_d;
            sync_q       <= {sync_q[1:0], wf_mem_clk};
            wr_ptr_q     <= flush ? '0 : wr_ptr_q + PTR_W'(accept);
            rd_ptr_q     <= flush ? '0 : rd_ptr_q + PTR_W'(pop);
            cnt_q        <= cnt_d;
            wr_addr_q    <= wr_addr_d;
            word_count_q <= word_count_d;
            overflow_q   <= overflow_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            ram_we_q     <= ram_we_d;
            busy_q       <= (state_d != S_IDLE);
            play_pipe_q  <= {play_pipe_q[0], play_en && (state_q == S_IDLE)};
        end
    end

    always_ff @(posedge clk) begin
        if (accept) fifo_mem[wr_ptr_q] <= wf_mem_data;
    end

    assign ram.ram_addr  = ram_addr_q;
    assign ram.ram_wdata = ram_wdata_q;
    assign ram.ram_we    = ram_we_q;
    assign play_rdata    = ram.ram_rdata;
    assign play_valid    = play_pipe_q[1];
    assign busy          = busy_q;
    assign overflow      = overflow_q;
    assign word_count    = word_count_q;
    assign dbg_state_o   = state_q;
endmodule
